// File: rtl/serie_paralelo_pkg.sv
// -----------------------------------------------------------------------------
// serie_paralelo_pkg
//   Shared definitions for the serial-to-parallel receiver:
//     - default comma (idle/alignment) byte
//     - phase counter width and the phase value that marks a byte boundary
//     - receiver FSM state encodings, as plain constants and as an enum
//   Imported by serie_paralelo and comma_detect.
// -----------------------------------------------------------------------------
package serie_paralelo_pkg;

  // Idle/alignment byte the transmitter sends whenever it has no valid data.
  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  // Bit position inside a byte; eight bits per byte.
  localparam int unsigned PH_W = 3;

  // Phase value at which the window holds a complete, aligned byte.
  localparam logic [PH_W-1:0] PH_LAST = 3'd7;

  // Receiver FSM encodings. The top keeps its state register as plain logic
  // compared against these constants; the enum gives readable names to
  // anything that decodes the fsm_state debug output.
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef enum logic [1:0] {
    SEARCH = ST_SEARCH,
    COUNT  = ST_COUNT,
    ACTIVE = ST_ACTIVE
  } sp_state_e;

endpackage

// File: rtl/serie_paralelo_comma_detect.sv
// -----------------------------------------------------------------------------
// comma_detect
//   Combinational compare of the current 8-bit receive window against the
//   comma byte. The flag feeds both the alignment FSM and the optional
//   loss-of-alignment logic in the top.
//
// Ports
//   win       in  8  byte ending with the bit sampled this cycle
//   is_comma  out 1  high when win equals COMMA
// -----------------------------------------------------------------------------
module comma_detect
  import serie_paralelo_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
  input  logic [7:0] win,
  output logic       is_comma
);

  assign is_comma = (win == COMMA);

endmodule

// File: rtl/serie_paralelo.sv
// -----------------------------------------------------------------------------
// serie_paralelo
//   Serial-to-parallel receiver for the single-bit link. Samples data_inS on
//   every rising clk_8f edge (MSB of each byte first), finds byte alignment
//   from the comma byte, and once ACTIVE_COUNT consecutive aligned commas have
//   been seen it presents every received byte on data_outP.
//
// Parameters
//   COMMA         alignment/idle byte (default 8'hBC)
//   ACTIVE_COUNT  consecutive aligned commas needed to go ACTIVE (1..15)
//
// Ports
//   clk_8f       in   1  bit-rate clock, the only clock
//   reset        in   1  asynchronous, active-high, clears all state
//   data_inS     in   1  serial data, one bit per clock, MSB first
//   data_outP    out  8  last byte received while ACTIVE (holds otherwise)
//   valid_out    out  1  data_outP holds a non-comma byte received in ACTIVE
//   active       out  1  receiver is in ACTIVE
//   byte_strobe  out  1  one-cycle pulse on every data_outP/valid_out update
//   fsm_state    out  2  debug view of the FSM (ST_SEARCH/ST_COUNT/ST_ACTIVE)
//
// Output handshake: there is no ready. A byte is delivered by byte_strobe
// being high for exactly one cycle; data_outP/valid_out change on the same
// edge that raises byte_strobe and then hold for 8 cycles. The consumer must
// take one byte per 8 clk_8f cycles; valid_out low with a strobe means the
// slot carried an idle comma.
//
// Build option
//   SP_RESYNC_EN  when defined, ACTIVE watches for commas that arrive off the
//                 byte boundary; the third such comma (with no aligned comma
//                 in between) sends the receiver back to SEARCH. Undefined,
//                 ACTIVE is left only through reset.
// -----------------------------------------------------------------------------
module serie_paralelo
  import serie_paralelo_pkg::*;
#(
  parameter logic [7:0]  COMMA        = COMMA_DEFAULT,
  parameter int unsigned ACTIVE_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_inS,
  output logic [7:0] data_outP,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe,
  output logic [1:0] fsm_state
);

  localparam logic [3:0] ACT_CNT = ACTIVE_COUNT[3:0];

  // Serial history. The window is the byte ending with the bit on data_inS
  // this cycle, so the oldest of the eight stored bits would never be read;
  // only seven are kept.
  logic [6:0]      sr;
  logic [7:0]      win;
  logic [PH_W-1:0] ph;
  logic [3:0]      comma_cnt;
  logic [3:0]      comma_cnt_inc;
  logic [1:0]      state;
  logic            is_comma;
  logic            boundary;

`ifdef SP_RESYNC_EN
  // Off-boundary commas seen in ACTIVE since the last aligned comma.
  logic [1:0]      mis_cnt;
`endif

  assign win           = {sr, data_inS};
  assign boundary      = (ph == PH_LAST);
  assign comma_cnt_inc = comma_cnt + 4'd1;

  comma_detect #(
    .COMMA (COMMA)
  ) u_comma_detect (
    .win      (win),
    .is_comma (is_comma)
  );

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      sr          <= '0;
      ph          <= '0;
      comma_cnt   <= '0;
      state       <= ST_SEARCH;
      data_outP   <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
`ifdef SP_RESYNC_EN
      mis_cnt     <= '0;
`endif
    end else begin
      sr          <= win[6:0];
      ph          <= ph + 3'd1;
      byte_strobe <= 1'b0;

      case (state)
        ST_SEARCH: begin
          valid_out <= 1'b0;
          // Any comma, at any phase, defines the byte boundary. Restarting
          // the phase here puts the next boundary exactly 8 bits later.
          if (is_comma) begin
            ph        <= '0;
            comma_cnt <= 4'd1;
            state     <= (ACT_CNT == 4'd1) ? ST_ACTIVE : ST_COUNT;
          end
        end

        ST_COUNT: begin
          valid_out <= 1'b0;
          // Only boundary windows matter; a comma elsewhere is ignored.
          if (boundary) begin
            if (is_comma) begin
              comma_cnt <= comma_cnt_inc;
              // The comma that completes the count is consumed here, so the
              // first byte delivered in ACTIVE is the one after it.
              if (comma_cnt_inc == ACT_CNT) begin
                state <= ST_ACTIVE;
              end
            end else begin
              comma_cnt <= '0;
              state     <= ST_SEARCH;
            end
          end
        end

        ST_ACTIVE: begin
          if (boundary) begin
            data_outP   <= win;
            valid_out   <= ~is_comma;
            byte_strobe <= 1'b1;
          end
`ifdef SP_RESYNC_EN
          if (is_comma && !boundary) begin
            if (mis_cnt == 2'd2) begin
              // Third off-boundary comma: the transmitter's framing has
              // moved, so give up this alignment and hunt for a new one.
              mis_cnt   <= '0;
              comma_cnt <= '0;
              valid_out <= 1'b0;
              state     <= ST_SEARCH;
            end else begin
              mis_cnt <= mis_cnt + 2'd1;
            end
          end else if (is_comma && boundary) begin
            mis_cnt <= '0;
          end
`endif
        end

        default: begin
          state <= ST_SEARCH;
        end
      endcase
    end
  end

  assign active    = (state == ST_ACTIVE);
  assign fsm_state = state;

endmodule

// File: tb/tb_serie_paralelo.sv
module tb_serie_paralelo;

  localparam logic [7:0] COMMA     = 8'hBC;
  localparam logic [1:0] ST_SEARCH = 2'd0;

  // ---------------------------------------------------------------- clock/reset
  logic       clk_8f = 1'b0;
  logic       reset;
  logic       data_inS;
  logic [7:0] data_outP;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;
  logic [1:0] fsm_state;

  always #5 clk_8f = ~clk_8f;

  serie_paralelo dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .data_inS    (data_inS),
    .data_outP   (data_outP),
    .valid_out   (valid_out),
    .active      (active),
    .byte_strobe (byte_strobe),
    .fsm_state   (fsm_state)
  );

  // ---------------------------------------------------------------- scoreboard
  // Each entry is {expected valid_out, expected data_outP} for one strobe.
  logic [8:0] exp_q[$];
  logic       sb_on;
  int         checks = 0;
  int         errors = 0;

  // ---------------------------------------------------------------- drivers
  task automatic apply_reset();
    @(negedge clk_8f);
    reset    = 1'b1;
    data_inS = 1'b0;
    @(negedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b0;
    exp_q.delete();
    sb_on = 1'b1;
  endtask

  // Drives one bit at a falling edge. Before changing the input, any strobe
  // produced by the previous rising edge is checked against the scoreboard.
  task automatic send_bit(input logic b);
    logic [8:0] exp_item;
    @(negedge clk_8f);
    if (sb_on && byte_strobe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: strobe with data_outP=%h valid_out=%b, required no strobe",
                 data_outP, valid_out);
      end else begin
        exp_item = exp_q.pop_front();
        if ({valid_out, data_outP} !== exp_item) begin
          errors++;
          $display("FAIL scoreboard_byte: got valid_out=%b data_outP=%h, required valid_out=%b data_outP=%h",
                   valid_out, data_outP, exp_item[8], exp_item[7:0]);
        end
      end
    end
    data_inS = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic expect_out);
    if (expect_out) exp_q.push_back({(b != COMMA), b});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_commas(input int n, input logic expect_out);
    for (int i = 0; i < n; i++) send_byte(COMMA, expect_out);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (data_outP !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", data_outP); end
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid_out); end
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b, required 0", active); end
    checks++;
    if (byte_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b, required 0", byte_strobe); end
    checks++;
    if (fsm_state !== ST_SEARCH) begin errors++; $display("FAIL reset_state: got %0d, required %0d", fsm_state, ST_SEARCH); end
  endtask

  task automatic test_lock();
    apply_reset();
    send_commas(3, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL lock_early: active=%b after 3 commas, required 0", active); end
    send_byte(COMMA, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL lock_active: active=%b after 4 commas, required 1", active); end
    send_byte(8'hA5, 1'b1);
    // Output updates on the edge that samples the last bit of the byte.
    @(posedge clk_8f); #1;
    checks++;
    if ({byte_strobe, valid_out, data_outP} !== {1'b1, 1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL lock_latency: strobe=%b valid=%b data=%h, required strobe=1 valid=1 data=a5",
               byte_strobe, valid_out, data_outP);
    end
    send_byte(8'h3C, 1'b1);
    send_byte(COMMA, 1'b1);
    send_bit(1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL lock_drain: %0d bytes not strobed, required 0", exp_q.size()); end
  endtask

  task automatic test_offset();
    apply_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    send_commas(4, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL offset_active: active=%b, required 1", active); end
    send_byte(8'h5A, 1'b1);
    send_byte(COMMA, 1'b1);
    send_bit(1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL offset_drain: %0d bytes not strobed, required 0", exp_q.size()); end
  endtask

  task automatic test_fail_relock();
    apply_reset();
    send_commas(2, 1'b0);
    send_byte(8'h11, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (fsm_state !== ST_SEARCH) begin errors++; $display("FAIL relock_search: state=%0d, required %0d", fsm_state, ST_SEARCH); end
    send_commas(3, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL relock_early: active=%b after 3 fresh commas, required 0", active); end
    send_byte(COMMA, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL relock_active: active=%b after 4 fresh commas, required 1", active); end
    send_byte(8'h77, 1'b1);
    send_byte(COMMA, 1'b1);
    send_bit(1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL relock_drain: %0d bytes not strobed, required 0", exp_q.size()); end
  endtask

  task automatic test_idle_commas();
    apply_reset();
    send_commas(4, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(COMMA, 1'b1);
    send_byte(8'h34, 1'b1);
    send_commas(2, 1'b1);
    send_bit(1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL idle_drain: %0d bytes not strobed, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    apply_reset();
    send_commas(4, 1'b0);
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, 1'b1);
      if (k % 4 == 3) send_byte(COMMA, 1'b1);
    end
    send_byte(COMMA, 1'b1);
    send_bit(1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d bytes not strobed, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_commas(4, 1'b0);
    send_byte(8'hE7, 1'b1);
    // First half of a comma, to be thrown away by the reset.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_pre: %0d bytes not strobed, required 0", exp_q.size()); end
    @(posedge clk_8f); #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({data_outP, valid_out, active, byte_strobe} !== 11'h000) begin
      errors++;
      $display("FAIL midrst_outputs: data=%h valid=%b active=%b strobe=%b, required all 0",
               data_outP, valid_out, active, byte_strobe);
    end
    @(negedge clk_8f);
    reset    = 1'b0;
    data_inS = 1'b1;
    exp_q.delete();
    // Second half of the comma; with a cleared history it is not a comma.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_commas(3, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL midrst_early: active=%b after 3 commas, required 0", active); end
    send_byte(COMMA, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL midrst_relock: active=%b after 4 commas, required 1", active); end
    send_byte(8'hC3, 1'b1);
    send_byte(COMMA, 1'b1);
    send_bit(1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_drain: %0d bytes not strobed, required 0", exp_q.size()); end
  endtask

`ifdef SP_RESYNC_EN
  task automatic test_resync();
    apply_reset();
    send_commas(4, 1'b0);
    send_commas(2, 1'b1);
    send_bit(1'b0);           // first slip bit; last aligned comma strobes here
    sb_on = 1'b0;             // bytes framed across the slip are not modelled
    send_bit(1'b0);           // second slip bit
    send_commas(2, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL resync_hold: active=%b after 2 slipped commas, required 1", active); end
    send_byte(COMMA, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL resync_drop: active=%b after 3 slipped commas, required 0", active); end
    exp_q.delete();
    sb_on = 1'b1;
    send_commas(3, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL resync_early: active=%b after 3 new commas, required 0", active); end
    send_byte(COMMA, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL resync_relock: active=%b after 4 new commas, required 1", active); end
    send_byte(8'h42, 1'b1);
    send_byte(COMMA, 1'b1);
    send_bit(1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL resync_drain: %0d bytes not strobed, required 0", exp_q.size()); end
  endtask
`else
  task automatic test_slip_hold();
    apply_reset();
    send_commas(4, 1'b0);
    send_byte(COMMA, 1'b1);
    send_bit(1'b0);
    sb_on = 1'b0;
    send_bit(1'b0);
    send_commas(5, 1'b0);
    @(posedge clk_8f); #1;
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL slip_hold: active=%b after 5 slipped commas, required 1", active); end
  endtask
`endif

  // ---------------------------------------------------------------- sequence
  initial begin
    reset    = 1'b1;
    data_inS = 1'b0;
    sb_on    = 1'b1;
    test_reset();
    test_lock();
    test_offset();
    test_fail_relock();
    test_idle_commas();
    test_back_to_back();
    test_reset_mid();
`ifdef SP_RESYNC_EN
    test_resync();
`else
    test_slip_hold();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
